// File: rtl/parity_byte_rx.sv
// parity_byte_rx: serial start/8N/parity/stop receiver with one-entry valid/ready buffer and sticky overrun
module parity_byte_rx #(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic [7:0] out_data,
  output logic       out_par_err,
  output logic       out_frm_err,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       ovr,
  input  logic       ovr_clr
);
  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;
  state_t state, state_n;
  logic [2:0] cnt;
  logic [7:0] sh;
  logic par;
  logic done, free;
  assign done = bit_valid && state == STOP;
  assign free = !out_valid || out_ready;
  always_comb begin
    state_n = state;
    if (bit_valid)
      case (state)
        IDLE:    state_n = bit_in ? IDLE : DATA;
        DATA:    state_n = cnt == 3'd7 ? PAR : DATA;
        PAR:     state_n = STOP;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      sh          <= '0;
      par         <= 1'b0;
      out_data    <= '0;
      out_par_err <= 1'b0;
      out_frm_err <= 1'b0;
      out_valid   <= 1'b0;
      ovr         <= 1'b0;
    end else begin
      if (bit_valid && state == IDLE && !bit_in) cnt <= '0;
      if (bit_valid && state == DATA) begin
        sh[cnt] <= bit_in;
        cnt     <= cnt + 3'd1;
      end
      if (bit_valid && state == PAR) par <= bit_in;
      if (done && free) begin
        out_data    <= sh;
        out_par_err <= (^{sh, par}) != PARITY_ODD;
        out_frm_err <= !bit_in;
        out_valid   <= 1'b1;
      end else if (out_valid && out_ready) out_valid <= 1'b0;
      ovr <= (done && !free) || (ovr && !ovr_clr);
    end
  end
endmodule

// File: tb/tb_parity_byte_rx.sv
// tb_parity_byte_rx: randomized frame-level check of parity_byte_rx against a queue-based reference model
module tb_parity_byte_rx;
  logic clk = 1'b0;
  logic rst, bit_in, bit_valid, out_ready, ovr_clr;
  logic [7:0] out_data, o_data;
  logic out_par_err, out_frm_err, out_valid, ovr;
  logic o_par_err, o_frm_err, o_valid, o_ovr;
  int passed = 0, total = 0;
  logic m_valid, m_pe, m_pe1, m_fe, m_ovr;
  logic [7:0] m_data;
  bit in_frame = 0;
  bit q[$];
  bit clr_rand = 0;
  always #5 clk = ~clk;
  parity_byte_rx #(.PARITY_ODD(1'b0)) u_even (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .out_data(out_data), .out_par_err(out_par_err), .out_frm_err(out_frm_err),
    .out_valid(out_valid), .out_ready(out_ready), .ovr(ovr), .ovr_clr(ovr_clr)
  );
  parity_byte_rx #(.PARITY_ODD(1'b1)) u_odd (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .out_data(o_data), .out_par_err(o_par_err), .out_frm_err(o_frm_err),
    .out_valid(o_valid), .out_ready(out_ready), .ovr(o_ovr), .ovr_clr(ovr_clr)
  );
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask
  task automatic check_outputs();
    chk("valid", 8'(out_valid), 8'(m_valid));
    chk("ovr", 8'(ovr), 8'(m_ovr));
    if (m_valid) begin
      chk("data", out_data, m_data);
      chk("par_err", 8'(out_par_err), 8'(m_pe));
      chk("frm_err", 8'(out_frm_err), 8'(m_fe));
      chk("odd_par_err", 8'(o_par_err), 8'(m_pe1));
      chk("odd_data", o_data, m_data);
    end
    chk("odd_valid", 8'(o_valid), 8'(m_valid));
  endtask
  task automatic model(input logic b, v, rd, cl, r);
    bit done, free, ovr_n;
    logic [7:0] d;
    int ones;
    if (r) begin
      in_frame = 0;
      q.delete();
      {m_valid, m_pe, m_pe1, m_fe, m_ovr} = '0;
      m_data = '0;
      return;
    end
    done = 0;
    if (v) begin
      if (!in_frame) begin
        if (!b) begin
          in_frame = 1;
          q.delete();
        end
      end else begin
        q.push_back(b);
        if (q.size() == 10) begin
          done = 1;
          in_frame = 0;
        end
      end
    end
    free = !m_valid || rd;
    ovr_n = (done && !free) || (m_ovr && !cl);
    if (done && free) begin
      d = '0;
      for (int i = 0; i < 8; i++) d[i] = q[i];
      ones = $countones(d) + int'(q[8]);
      m_data = d;
      m_pe = (ones % 2) != 0;
      m_pe1 = (ones % 2) != 1;
      m_fe = !q[9];
      m_valid = 1;
    end else if (m_valid && rd) m_valid = 0;
    m_ovr = ovr_n;
  endtask
  task automatic cycle(input logic b, v, rd, cl, r);
    bit_in = b;
    bit_valid = v;
    out_ready = rd;
    ovr_clr = cl;
    rst = r;
    @(posedge clk);
    model(b, v, rd, cl, r);
    #1;
    check_outputs();
  endtask
  function automatic logic rdy_of(input int mode, input bit is_stop);
    return mode == 0 ? 1'b0 : mode == 1 ? 1'b1 : mode == 2 ? logic'($urandom_range(0, 1)) : logic'(is_stop);
  endfunction
  function automatic logic clr_of();
    return clr_rand && ($urandom_range(0, 7) == 0);
  endfunction
  task automatic send_frame(input logic [7:0] d, input logic p, s, input bit gaps, input int mode);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      if (gaps && $urandom_range(0, 1) == 1)
        repeat ($urandom_range(1, 5)) cycle(logic'($urandom_range(0, 1)), 1'b0, rdy_of(mode, 0), clr_of(), 1'b0);
      cycle(bits[i], 1'b1, rdy_of(mode, i == 10), clr_of(), 1'b0);
    end
  endtask
  initial begin
    {rst, bit_in, bit_valid, out_ready, ovr_clr} = '0;
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_data", out_data, 8'h00);
    chk("rst_valid", 8'(out_valid), 8'h00);
    chk("rst_ovr", 8'(ovr), 8'h00);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(8'h05, 1'b0, 1'b1, 0, 1);
    chk("basic_valid", 8'(out_valid), 8'h01);
    chk("basic_data", out_data, 8'h05);
    chk("basic_pe", 8'(out_par_err), 8'h00);
    chk("basic_fe", 8'(out_frm_err), 8'h00);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("basic_popped", 8'(out_valid), 8'h00);
    send_frame(8'hA5, 1'b1, 1'b0, 0, 0);
    chk("err_data", out_data, 8'hA5);
    chk("err_pe", 8'(out_par_err), 8'h01);
    chk("err_fe", 8'(out_frm_err), 8'h01);
    chk("err_odd_pe", 8'(o_par_err), 8'h00);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b1, 1, 0);
    chk("gap_data", out_data, 8'h3C);
    chk("gap_pe", 8'(out_par_err), 8'h00);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h11, 1'b0, 1'b1, 0, 0);
    send_frame(8'h22, 1'b0, 1'b1, 0, 0);
    chk("ovr_data", out_data, 8'h11);
    chk("ovr_set", 8'(ovr), 8'h01);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ovr_pop", 8'(out_valid), 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovr_clr", 8'(ovr), 8'h00);
    send_frame(8'h11, 1'b0, 1'b1, 0, 0);
    send_frame(8'h22, 1'b0, 1'b1, 0, 3);
    chk("sim_data", out_data, 8'h22);
    chk("sim_valid", 8'(out_valid), 8'h01);
    chk("sim_ovr", 8'(ovr), 8'h00);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(logic'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("mid_rst_data", out_data, 8'h00);
    chk("mid_rst_valid", 8'(out_valid), 8'h00);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("mid_rst_idle", 8'(out_valid), 8'h00);
    send_frame(8'hF0, 1'b0, 1'b1, 0, 1);
    chk("mid_rst_f0", out_data, 8'hF0);
    chk("mid_rst_f0_valid", 8'(out_valid), 8'h01);
    clr_rand = 1;
    for (int n = 0; n < 150; n++) begin
      send_frame(8'($urandom), logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) != 0),
                 bit'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
      repeat ($urandom_range(0, 2)) cycle(1'b1, logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), clr_of(), 1'b0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/parity_byte_rx.md
Name: parity_byte_rx

Overview:
- Serial frame receiver that sits directly upstream of the 8-bit even parity detector.
- Accepts one bit per enabled clock in the frame format start(0), D0..D7 (LSB first), parity bit P, stop(1).
- Assembles the byte and checks parity over {D7..D0, P}.
- Presents the byte, parity-error and framing-error flags through a one-entry valid/ready output buffer with sticky overrun detection.

Parameters:
- PARITY_ODD, 0, 0 = even parity: the count of ones over the 8 data bits plus P must be even. 1 = odd parity: that count must be odd.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_in  input  1  serial data bit; sampled only when bit_valid=1.
- bit_valid  input  1  qualifies bit_in for this cycle; when low, the FSM holds state.
- out_data  output  8  received byte, D0 in bit 0.
- out_par_err  output  1  parity check failed for out_data.
- out_frm_err  output  1  stop bit sampled as 0 for out_data.
- out_valid  output  1  output buffer holds an unconsumed frame.
- out_ready  input  1  consumer accepts; transfer occurs when out_valid&&out_ready.
- ovr  output  1  sticky overrun flag: a completed frame was dropped because the buffer was full.
- ovr_clr  input  1  clears ovr.

Behaviour:
- Reset (rst=1 at a clock edge):
  - FSM goes to IDLE; bit counter=0; shift register=0.
  - out_data=8'h00, out_par_err=0, out_frm_err=0, out_valid=0, ovr=0.
  - Applies mid-frame too: the partial frame is discarded.
- FSM state IDLE: on bit_valid && bit_in==0 (start bit), go to DATA with cnt=0. A 1 while bit_valid is high is line idle; stay in IDLE.
- FSM state DATA: on each bit_valid, shift bit_in into position cnt (LSB first) and increment cnt. After the 8th bit (cnt==7 when sampled), go to PAR.
- FSM state PAR: on bit_valid, latch P and go to STOP.
- FSM state STOP: on bit_valid, sample the stop bit and complete the frame. Return to IDLE. The stop bit is consumed even if it is 0; there is no resynchronisation hunt.
- bit_valid=0 in any state: no shift, no count, no transition.
- Parity rule: par_err = (^{data[7:0],P}) != PARITY_ODD.
- Frame rule: frm_err = (stop bit == 0).
- Completion write: on the stop-bit edge, if the buffer is free, load out_data/out_par_err/out_frm_err and set out_valid=1. These values are visible the cycle after the stop bit is sampled (latency = 1 clock from stop-bit edge).
- Buffer free is defined as out_valid==0, or out_valid&&out_ready in the same cycle. Simultaneous pop and completion therefore loads the new frame with out_valid staying 1, and this is not an overrun.
- Overrun: completion while out_valid==1 and out_ready==0:
  - the new frame is dropped;
  - the buffer keeps the old frame unchanged;
  - ovr is set to 1.
- ovr stays 1 until ovr_clr=1 or rst. If ovr_clr and a new overrun occur in the same cycle, set wins (ovr=1).
- Pop without completion: out_valid&&out_ready and no completion gives out_valid=0 next cycle. out_data and the flags hold their last values.
- While out_valid=1, out_data and the flags are stable until popped.
- The receiver keeps accepting bits regardless of out_ready; there is no backpressure to the serial side.
- Back-to-back frames are allowed: a start bit in the cycle right after STOP returns to IDLE is accepted.

Test Plan:
- Basic even frame: rst, then bits 0, 1,0,1,0,0,0,0,0 (byte 8'h05), P=0, stop=1, out_ready=1 -> out_valid=1 for 1 cycle with out_data=8'h05, par_err=0, frm_err=0; check the 1-cycle latency after the stop edge.
- Parity and frame errors: byte 8'hA5 with P=1 and stop=0 -> out_data=8'hA5, par_err=1, frm_err=1. With PARITY_ODD=1 and P=1 -> par_err=0.
- Gapped input: insert random bit_valid=0 gaps (1-5 cycles) inside the frame for 8'h3C, P=0 -> same result as gapless; FSM holds during gaps.
- Overrun: hold out_ready=0 and send 8'h11 then 8'h22 -> out_data stays 8'h11 and ovr=1. Then pop -> out_valid=0. Pulse ovr_clr -> ovr=0.
- Simultaneous pop and completion: buffer holds 8'h11; assert out_ready exactly on the stop-bit edge of frame 8'h22 -> out_data=8'h22, out_valid stays 1, ovr=0.
- Reset mid-frame: assert rst after the 4th data bit, then send a full frame 8'hF0 -> only 8'hF0 is delivered; all outputs read 0 during and after reset until that completion.
